// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the keypad front end.
//   state_e   - scan/debounce FSM states
//   KEY_STAR  - code for '*', KEY_HASH - code for '#'
//   keymap    - (row, active-low column pattern) -> key code
//   one_low   - true when exactly one column of a pattern is low
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  // Rows 0..2 carry digits 1..9; row 3 is '*', '0', '#'.
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [2:0] col_n);
    logic [1:0] col;
    col = (!col_n[0]) ? 2'd0 : ((!col_n[1]) ? 2'd1 : 2'd2);
    if (row == 2'd3) begin
      case (col)
        2'd0:    return KEY_STAR;
        2'd1:    return 4'd0;
        default: return KEY_HASH;
      endcase
    end
    return 4'(row) * 4'd3 + 4'(col) + 4'd1;
  endfunction

  function automatic logic one_low(input logic [2:0] col_n);
    return (col_n == 3'b110) || (col_n == 3'b101) || (col_n == 3'b011);
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// keypad_col_sync: two-flop synchroniser for the asynchronous column returns.
//   clk, rst  - clock, asynchronous active-high reset
//   col_in    - raw active-low column inputs
//   col_sync  - synchronised columns; idle (all-high) out of reset
module keypad_col_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] col_in,
  output logic [2:0] col_sync
);

  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;

  always_comb begin
    meta_d = col_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 3'b111;
      sync_q <= 3'b111;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign col_sync = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x3 matrix keypad scanner with debounce and one-cycle key pulses.
//   clk, rst     - 1 kHz clock, asynchronous active-high reset
//   key_col      - active-low column returns (asynchronous)
//   key_row      - one-hot active-low row drive
//   digit        - last accepted key code (0-9, 'A' = '*', 'B' = '#')
//   digit_valid  - pulse: new digit accepted
//   set_pulse    - pulse: '*' accepted
//   clr_pulse    - pulse: '#' accepted
//   key_busy     - high whenever the FSM is outside SCAN
// Optional: define KEYPAD_REPEAT_EN for digit auto-repeat while held.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned ROW_DWELL    = 4,
  parameter int unsigned DEBOUNCE_MS  = 20,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       set_pulse,
  output logic       clr_pulse,
  output logic       key_busy
);

  localparam int unsigned MAX_DR  = (DEBOUNCE_MS > REPEAT_DELAY) ? DEBOUNCE_MS : REPEAT_DELAY;
  localparam int unsigned CNT_MAX = (MAX_DR > REPEAT_RATE) ? MAX_DR : REPEAT_RATE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned DWELL_W = $clog2(ROW_DWELL);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROW_DWELL - 1);
  localparam logic [CNT_W-1:0]   DEB_LAST   = CNT_W'(DEBOUNCE_MS - 1);

  logic [2:0] cs;

  keypad_col_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .col_in   (key_col),
    .col_sync (cs)
  );

  state_e             state_q, state_d;
  logic [1:0]         row_q, row_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         cap_q, cap_d;
  logic [3:0]         digit_q, digit_d;
  logic [3:0]         key_row_q, key_row_d;
  logic               dv_q, dv_d;
  logic               set_q, set_d;
  logic               clr_q, clr_d;
  logic               busy_q, busy_d;
  logic [3:0]         code_c;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_FIRST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_NEXT  = CNT_W'(REPEAT_RATE - 1);
  // Set after the first repeat so later repeats use the shorter period.
  logic rep_armed_q, rep_armed_d;
`endif

  assign code_c = keymap(row_q, cap_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    digit_d = digit_q;
    dv_d    = 1'b0;
    set_d   = 1'b0;
    clr_d   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_armed_d = rep_armed_q;
`endif

    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          if (one_low(cs)) begin
            // Row stays frozen so the same key keeps driving its column.
            cap_d   = cs;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            row_d   = row_q + 2'd1;
            dwell_d = '0;
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end

      DEBOUNCE: begin
        if (cs != cap_q) begin
          state_d = SCAN;
          row_d   = 2'd0;
          dwell_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          digit_d = code_c;
          if (code_c == KEY_STAR)      set_d = 1'b1;
          else if (code_c == KEY_HASH) clr_d = 1'b1;
          else                         dv_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
          rep_armed_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HOLD: begin
        if (cs == 3'b111) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          if (digit_q < 4'd10) begin
            if ((!rep_armed_q && cnt_q == REP_FIRST) || (rep_armed_q && cnt_q == REP_NEXT)) begin
              dv_d        = 1'b1;
              cnt_d       = '0;
              rep_armed_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
`endif
        end
      end

      RELEASE: begin
        if (cs != 3'b111) begin
          state_d = HOLD;
          cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
          rep_armed_d = 1'b0;
`endif
        end else if (cnt_q == DEB_LAST) begin
          state_d = SCAN;
          row_d   = 2'd0;
          dwell_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = SCAN;
    endcase

    key_row_d = ~(4'b0001 << row_d);
    busy_d    = (state_d != SCAN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      row_q     <= 2'd0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      cap_q     <= 3'b111;
      digit_q   <= 4'd0;
      key_row_q <= 4'b1110;
      dv_q      <= 1'b0;
      set_q     <= 1'b0;
      clr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      digit_q   <= digit_d;
      key_row_q <= key_row_d;
      dv_q      <= dv_d;
      set_q     <= set_d;
      clr_q     <= clr_d;
      busy_q    <= busy_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep_armed_q <= 1'b0;
    else     rep_armed_q <= rep_armed_d;
  end
`endif

  assign key_row     = key_row_q;
  assign digit       = digit_q;
  assign digit_valid = dv_q;
  assign set_pulse   = set_q;
  assign clr_pulse   = clr_q;
  assign key_busy    = busy_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: randomized and directed bench for keypad_scan with a
// physical keypad model and a pulse scoreboard.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_col;
  logic [3:0] key_row;
  logic [3:0] digit;
  logic       digit_valid, set_pulse, clr_pulse, key_busy;

  logic [11:0] pressed;   // index = row*3 + col
  int          cyc;
  int          checks   = 0;
  int          failures = 0;

  typedef struct {
    int kind;   // 0 digit, 1 set, 2 clr
    int code;
    int lo;
    int hi;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  keypad_scan dut (
    .clk         (clk),
    .rst         (rst),
    .key_col     (key_col),
    .key_row     (key_row),
    .digit       (digit),
    .digit_valid (digit_valid),
    .set_pulse   (set_pulse),
    .clr_pulse   (clr_pulse),
    .key_busy    (key_busy)
  );

  // Passive matrix: a pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    key_col = 3'b111;
    for (int r = 0; r < 4; r++)
      if (!key_row[r])
        for (int c = 0; c < 3; c++)
          if (pressed[r*3+c]) key_col[c] = 1'b0;
  end

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  function automatic int code_of(input int k);
    case (k)
      9:       return 10;
      10:      return 0;
      11:      return 11;
      default: return k + 1;
    endcase
  endfunction

  function automatic int kind_of(input int k);
    return (k == 9) ? 1 : ((k == 11) ? 2 : 0);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=[%0d..%0d]", name, act, lo, hi);
    end
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  always @(posedge clk) begin : mon
    int   n;
    int   k;
    exp_t e;
    #1;
    if (!rst) begin
      n = int'(digit_valid) + int'(set_pulse) + int'(clr_pulse);
      if (n != 0) begin
        chk("one_pulse_at_a_time", n, 1);
        k = digit_valid ? 0 : (set_pulse ? 1 : 2);
        if (exp_q.size() == 0) begin
          chk("pulse_expected_pending", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", k, e.kind);
          chk("pulse_digit", int'(digit), e.code);
          chk_range("pulse_cycle", cyc, e.lo, e.hi);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic push(input int kind, input int code, input int lo, input int hi);
    exp_t e;
    e.kind = kind; e.code = code; e.lo = lo; e.hi = hi;
    exp_q.push_back(e);
  endtask

  // A clean press from SCAN is found within one 16-cycle scan, after 2 sync
  // cycles, then accepted DEBOUNCE_MS edges later.
  task automatic press(input int k, input int hold, input int gap);
    int p;
    pressed[k] = 1'b1;
    p = cyc;
    push(kind_of(k), code_of(k), p + 23, p + 38);
    step(hold);
    pressed[k] = 1'b0;
    step(gap);
  endtask

  initial begin
    int s;
    logic [3:0] exp_row;
    pressed = '0;
    rst = 1'b1;
    do_reset();

    // Reset values.
    chk("rst_key_row", int'(key_row), int'(4'b1110));
    chk("rst_digit", int'(digit), 0);
    chk("rst_digit_valid", int'(digit_valid), 0);
    chk("rst_set_pulse", int'(set_pulse), 0);
    chk("rst_clr_pulse", int'(clr_pulse), 0);
    chk("rst_key_busy", int'(key_busy), 0);

    // Idle rotation: 4 cycles per row.
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      chk("scan_row", int'(key_row), int'(exp_row));
      chk("scan_busy", int'(key_busy), 0);
    end
    #1;

    // Key 7 held from reset: row 2 sampled at edge 12, accepted at edge 32.
    pressed[6] = 1'b1;
    do_reset();
    push(0, 7, 32, 32);
    step(100);
    pressed[6] = 1'b0;
    step(60);

    // Bouncing 5, final press held steady.
    s = 0;
    for (int i = 0; i < 5; i++) begin
      pressed[4] = (i % 2 == 0);
      if (i == 4) s = cyc;
      step(3);
    end
    push(0, 5, s + 23, s + 38);
    step(60);
    pressed[4] = 1'b0;
    step(60);

    // '*' then '#'.
    press(9, 50, 50);
    press(11, 50, 50);
    chk("digit_holds_hash", int'(digit), 11);

    // Two columns in row 0 together: never a single-column hit.
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    step(100);
    chk("two_col_not_busy", int'(key_busy), 0);
    pressed = '0;
    step(30);

    // Key 3 held 1000 cycles from reset: row 0 sampled at edge 4, accepted at 24.
    pressed[2] = 1'b1;
    do_reset();
    push(0, 3, 24, 24);
`ifdef KEYPAD_REPEAT_EN
    push(0, 3, 524, 524);
    push(0, 3, 724, 724);
    push(0, 3, 924, 924);
`endif
    step(1000);
    pressed[2] = 1'b0;
    step(60);

    // Random clean presses.
    for (int n = 0; n < 10; n++)
      press($urandom_range(0, 11), 50 + $urandom_range(0, 40), 45 + $urandom_range(0, 30));

    // Reset in the middle of DEBOUNCE.
    press(8, 50, 50);
    pressed[6] = 1'b1;
    step(20);
    chk("mid_debounce_busy", int'(key_busy), 1);
    chk("mid_debounce_digit", int'(digit), 9);
    #1 rst = 1'b1;
    #1;
    chk("abort_key_row", int'(key_row), int'(4'b1110));
    chk("abort_digit", int'(digit), 0);
    chk("abort_digit_valid", int'(digit_valid), 0);
    chk("abort_set_pulse", int'(set_pulse), 0);
    chk("abort_clr_pulse", int'(clr_pulse), 0);
    chk("abort_key_busy", int'(key_busy), 0);
    pressed = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step(50);

    chk("pending_expectations", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
